rptr_empty_ctl: RTL and testbench

- Read-side pointer and flag controller for the dual-clock asynchronous FIFO; counterpart of the write-pointer/full logic.
- Owns the read binary and Gray pointers, the RAM read address, the registered empty flag, a registered almost-empty flag and the read-side fill level.
- Lives entirely in the rclk domain.
- Takes the write Gray pointer already passed through the two-flop synchronizer (rq2_wptr); this block adds no synchronizers.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rptr_empty_ctl.sv | 81 ++++++++
 tb/tb_rptr_empty_ctl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width, depth and Gray/binary conversions.
package fifo_pkg;

  localparam int unsigned ADDRSIZE = 4;
  localparam int unsigned DEPTH    = 2 ** ADDRSIZE;

  // Width-agnostic: callers zero-extend into 32 bits and size-cast the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_ctl.sv
// Read-side pointer, empty/almost-empty flag and fill-level controller (rclk domain).
// Optional sticky underflow flag: define RPTR_UNDERFLOW_FLAG_EN.
module rptr_empty_ctl #(
  parameter int unsigned ADDRSIZE  = fifo_pkg::ADDRSIZE,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_UNDERFLOW_FLAG_EN
  ,
  output logic                runderflow
`endif
);
  import fifo_pkg::*;

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_T = PW'(AE_THRESH);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic              r_empty;
  logic              r_aempty;
  logic [ADDRSIZE:0] r_level;

  logic              w_rd;
  logic [ADDRSIZE:0] w_binnext;
  logic [ADDRSIZE:0] w_graynext;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_lvlnext;

  assign w_rd       = rinc & ~r_empty;
  assign w_binnext  = r_bin + PW'(w_rd);
  assign w_graynext = PW'(bin2gray(32'(w_binnext)));
  assign w_wbin     = PW'(gray2bin(32'(rq2_wptr)));
  // Modulo subtraction over the full pointer width keeps the lap bit, so 2**ADDRSIZE reads as full.
  assign w_lvlnext  = w_wbin - w_binnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_bin    <= '0;
      r_ptr    <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_level  <= '0;
    end else begin
      r_bin    <= w_binnext;
      r_ptr    <= w_graynext;
      r_empty  <= (w_graynext == rq2_wptr);
      r_aempty <= (w_lvlnext <= AE_T);
      r_level  <= w_lvlnext;
    end
  end

`ifdef RPTR_UNDERFLOW_FLAG_EN
  logic r_underflow;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_underflow <= 1'b0;
    end else if (rinc && r_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign runderflow = r_underflow;
`endif

  assign raddr   = r_bin[ADDRSIZE-1:0];
  assign rptr    = r_ptr;
  assign rempty  = r_empty;
  assign raempty = r_aempty;
  assign rlevel  = r_level;

endmodule

// File: tb/tb_rptr_empty_ctl.sv
// Bench for rptr_empty_ctl: directed steps plus randomized traffic against a counter-based model.
module tb_rptr_empty_ctl;

  logic       rclk;
  logic       rrst;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
`ifdef RPTR_UNDERFLOW_FLAG_EN
  logic       runderflow;
`endif

  rptr_empty_ctl #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rinc     (rinc),
    .rq2_wptr (rq2_wptr),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty),
    .raempty  (raempty),
    .rlevel   (rlevel)
`ifdef RPTR_UNDERFLOW_FLAG_EN
    ,
    .runderflow(runderflow)
`endif
  );

  logic clk_en = 1'b0;
  initial begin
    rclk = 1'b0;
    wait (clk_en);
    forever #5 rclk = ~rclk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference state: read count and write count modulo 32, plus derived flags.
  int m_r, m_w, m_level;
  bit m_empty, m_ae, m_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_w = 0; m_level = 0;
    m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    int g;
    g = m_r ^ (m_r >> 1);
    chk({tag, ".rempty"},  32'(rempty),  32'(m_empty));
    chk({tag, ".raempty"}, 32'(raempty), 32'(m_ae));
    chk({tag, ".rlevel"},  32'(rlevel),  32'(m_level));
    chk({tag, ".rptr"},    32'(rptr),    32'(g));
    chk({tag, ".raddr"},   32'(raddr),   32'(m_r % 16));
`ifdef RPTR_UNDERFLOW_FLAG_EN
    chk({tag, ".runderflow"}, 32'(runderflow), 32'(m_uf));
`endif
  endtask

  // Apply one cycle: inputs settle, model advances, DUT samples, outputs checked 1 time unit later.
  task automatic step(input string tag, input bit inc, input int wbin);
    bit rd;
    rinc     = inc;
    rq2_wptr = 5'(wbin ^ (wbin >> 1));
    rd = inc && !m_empty;
    if (inc && m_empty) m_uf = 1'b1;
    m_r     = (m_r + (rd ? 1 : 0)) % 32;
    m_level = (wbin - m_r + 32) % 32;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= 2);
    @(posedge rclk);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    #2;
    rrst = 1'b0;
    model_reset();
  endtask

  initial begin
    rinc = 1'b0;
    rq2_wptr = '0;
    rrst = 1'b0;
    #1;
    rrst = 1'b1;
    #2;
    model_reset();
    chk_all("reset");
    rrst = 1'b0;
    #1;
    clk_en = 1'b1;
    @(posedge rclk);
    #1;

    // Fill then drain
    step("fill3", 1'b0, 3);
    chk("fill3.level_c", 32'(rlevel), 32'd3);
    step("rd1", 1'b1, 3);
    chk("rd1.rptr_c", 32'(rptr), 32'b00001);
    step("rd2", 1'b1, 3);
    step("rd3", 1'b1, 3);
    chk("rd3.rempty_c", 32'(rempty), 32'd1);
    chk("rd3.raddr_c", 32'(raddr), 32'd3);
    step("rd4_ignored", 1'b1, 3);
    chk("rd4.raddr_c", 32'(raddr), 32'd3);

    // Full view from the read side
    do_reset();
    step("full", 1'b0, 16);
    chk("full.level_c", 32'(rlevel), 32'd16);
    step("full_rd", 1'b1, 16);

    // Mid-read asynchronous reset at level 5
    do_reset();
    step("lvl5", 1'b0, 5);
    #2;
    rrst = 1'b1;
    #1;
    model_reset();
    chk_all("midreset");
    #1;
    rrst = 1'b0;
    step("post_rst0", 1'b0, 0);
    step("post_rst0b", 1'b1, 0);
    step("post_rst1", 1'b0, 1);

    // Randomized streaming: covers pointer wrap 31 -> 0 and level up to 16
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (((m_w - m_r + 32) % 32) < 16 && $urandom_range(0, 2) != 0)
        m_w = (m_w + 1) % 32;
      step("rand", 1'($urandom_range(0, 1)), m_w);
    end
    // Drain completely, then keep reading past empty
    for (int i = 0; i < 20; i++) begin
      step("drain", 1'b1, m_w);
    end
    chk("drain.rempty_c", 32'(rempty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
